// File: rtl/mul_chain.sv
// mul_chain: pops NUM_OPS operands from a FIFO, multiplies them iteratively and pushes the P-bit product as NUM_OPS words; MUL_CHAIN_CNT_EN adds a result counter
module mul_chain #(
  parameter int RAH_PACKET_WIDTH = 48,
  parameter int NUM_OPS = 2,
  parameter bit SIGNED = 1'b0,
  parameter bit MSW_FIRST = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [RAH_PACKET_WIDTH-1:0] a,
  input  logic                        empty,
  input  logic                        full,
  output logic                        rden,
  output logic [RAH_PACKET_WIDTH-1:0] c,
  output logic                        wren,
  output logic                        busy
`ifdef MUL_CHAIN_CNT_EN
  ,
  output logic [15:0]                 result_cnt
`endif
);
  localparam int W = RAH_PACKET_WIDTH;
  localparam int P = NUM_OPS * W;
  localparam logic [2:0] LAST = 3'(NUM_OPS - 1);
  localparam logic [2:0] NW = 3'(NUM_OPS);
  typedef enum logic [1:0] {IDLE, RD, WT, WRITE} state_t;
  state_t state, state_n;
  logic [P-1:0] acc, acc_n, ext_a;
  logic [2:0] idx, idx_n, widx, widx_n, sel;
  logic [W-1:0] c_n;
  logic rden_n, wren_n;
`ifdef MUL_CHAIN_CNT_EN
  logic [15:0] cnt_n;
`endif
  assign ext_a = SIGNED ? {{(P-W){a[W-1]}}, a} : {{(P-W){1'b0}}, a};
  assign sel = MSW_FIRST ? LAST - widx : widx;
  assign busy = state != IDLE || idx != 3'd0;
  // next state and next values of every registered output and datapath register
  always_comb begin
    state_n = state;
    rden_n = 1'b0;
    wren_n = 1'b0;
    c_n = c;
    acc_n = acc;
    idx_n = idx;
    widx_n = widx;
`ifdef MUL_CHAIN_CNT_EN
    cnt_n = result_cnt;
`endif
    case (state)
      IDLE: begin
        rden_n = !empty;
        state_n = empty ? IDLE : RD;
      end
      RD: state_n = WT;
      WT: begin
        acc_n = idx == 3'd0 ? ext_a : acc * ext_a;
        idx_n = idx == LAST ? 3'd0 : idx + 3'd1;
        widx_n = 3'd0;
        state_n = idx == LAST ? WRITE : IDLE;
      end
      WRITE: begin
        if (widx == NW) begin
          state_n = IDLE;
        end else if (!full) begin
          c_n = acc[sel*W +: W];
          wren_n = 1'b1;
          widx_n = widx + 3'd1;
`ifdef MUL_CHAIN_CNT_EN
          cnt_n = widx == LAST ? result_cnt + 16'd1 : result_cnt;
`endif
        end
      end
      default: state_n = IDLE;
    endcase
  end
  // state and output registers, cleared asynchronously so a reset drops any partial result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rden <= 1'b0;
      wren <= 1'b0;
      c <= '0;
      acc <= '0;
      idx <= 3'd0;
      widx <= 3'd0;
`ifdef MUL_CHAIN_CNT_EN
      result_cnt <= 16'd0;
`endif
    end else begin
      state <= state_n;
      rden <= rden_n;
      wren <= wren_n;
      c <= c_n;
      acc <= acc_n;
      idx <= idx_n;
      widx <= widx_n;
`ifdef MUL_CHAIN_CNT_EN
      result_cnt <= cnt_n;
`endif
    end
  end
endmodule

// File: tb/tb_mul_chain.sv
// tb_mul_chain: directed vectors for mul_chain across unsigned/LSW-first/signed/3-operand instances
module tb_mul_chain;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic full = 1'b0;
  logic [47:0] a0, a3, c0, c1, c2, c3;
  logic empty0, empty3, rden0, rden1, rden2, rden3;
  logic wren0, wren1, wren2, wren3, busy0, busy1, busy2, busy3;
`ifdef MUL_CHAIN_CNT_EN
  logic [15:0] cnt0, cnt1, cnt2, cnt3;
`endif
  logic [47:0] mem0[64];
  logic [47:0] mem3[64];
  int wp0 = 0, rp0 = 0, wp3 = 0, rp3 = 0;
  logic [47:0] o0[$], o1[$], o2[$], o3[$];
  int tests = 0, errors = 0;
  typedef struct {
    logic [47:0] x, y, m0, m1, l0, l1, s0, s1;
  } vec_t;
  vec_t tv[5];
  logic [13:0] rm, wm;
  int k;

  always #5 clk = ~clk;

  mul_chain #(.NUM_OPS(2)) u0 (.clk(clk), .rst_n(rst_n), .a(a0), .empty(empty0), .full(full),
    .rden(rden0), .c(c0), .wren(wren0), .busy(busy0)
`ifdef MUL_CHAIN_CNT_EN
    , .result_cnt(cnt0)
`endif
  );
  mul_chain #(.NUM_OPS(2), .MSW_FIRST(1'b0)) u1 (.clk(clk), .rst_n(rst_n), .a(a0), .empty(empty0), .full(full),
    .rden(rden1), .c(c1), .wren(wren1), .busy(busy1)
`ifdef MUL_CHAIN_CNT_EN
    , .result_cnt(cnt1)
`endif
  );
  mul_chain #(.NUM_OPS(2), .SIGNED(1'b1)) u2 (.clk(clk), .rst_n(rst_n), .a(a0), .empty(empty0), .full(full),
    .rden(rden2), .c(c2), .wren(wren2), .busy(busy2)
`ifdef MUL_CHAIN_CNT_EN
    , .result_cnt(cnt2)
`endif
  );
  mul_chain #(.NUM_OPS(3)) u3 (.clk(clk), .rst_n(rst_n), .a(a3), .empty(empty3), .full(full),
    .rden(rden3), .c(c3), .wren(wren3), .busy(busy3)
`ifdef MUL_CHAIN_CNT_EN
    , .result_cnt(cnt3)
`endif
  );

  assign empty0 = rp0 == wp0;
  assign empty3 = rp3 == wp3;

  always @(posedge clk) begin
    if (rden0 && rp0 != wp0) begin
      a0 <= mem0[rp0[5:0]];
      rp0 <= rp0 + 1;
    end
    if (rden3 && rp3 != wp3) begin
      a3 <= mem3[rp3[5:0]];
      rp3 <= rp3 + 1;
    end
  end

  always @(negedge clk) begin
    if (wren0) o0.push_back(c0);
    if (wren1) o1.push_back(c1);
    if (wren2) o2.push_back(c2);
    if (wren3) o3.push_back(c3);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp_v);
    end
  endtask

  task automatic push0(input logic [47:0] v);
    mem0[wp0[5:0]] = v;
    wp0 = wp0 + 1;
  endtask

  task automatic push3(input logic [47:0] v);
    mem3[wp3[5:0]] = v;
    wp3 = wp3 + 1;
  endtask

  task automatic clear_q();
    o0.delete();
    o1.delete();
    o2.delete();
    o3.delete();
  endtask

  function automatic int qsz(input int w);
    return w == 0 ? o0.size() : w == 1 ? o1.size() : w == 2 ? o2.size() : o3.size();
  endfunction

  task automatic wait_q(input int w, input int n);
    for (int i = 0; i < 300 && qsz(w) < n; i++) @(negedge clk);
    if (qsz(w) < n) begin
      tests++;
      errors++;
      $display("FAIL wait_q%0d: got %0d words expected %0d", w, qsz(w), n);
    end
  endtask

  task automatic wait_rden(input int which, input int n);
    k = 0;
    for (int i = 0; i < 100 && k < n; i++) begin
      @(negedge clk);
      if (which == 0 ? rden0 : rden3) k++;
    end
    if (k < n) begin
      tests++;
      errors++;
      $display("FAIL wait_rden%0d: got %0d pulses expected %0d", which, k, n);
    end
  endtask

  initial begin
    tv[0] = '{48'd3, 48'd5, 48'h0, 48'hF, 48'hF, 48'h0, 48'h0, 48'hF};
    tv[1] = '{48'hFFFFFFFFFFFF, 48'hFFFFFFFFFFFF, 48'hFFFFFFFFFFFE, 48'h1, 48'h1, 48'hFFFFFFFFFFFE, 48'h0, 48'h1};
    tv[2] = '{48'hFFFFFFFFFFFE, 48'd3, 48'h2, 48'hFFFFFFFFFFFA, 48'hFFFFFFFFFFFA, 48'h2, 48'hFFFFFFFFFFFF, 48'hFFFFFFFFFFFA};
    tv[3] = '{48'd6, 48'd7, 48'h0, 48'h2A, 48'h2A, 48'h0, 48'h0, 48'h2A};
    tv[4] = '{48'h800000000000, 48'd2, 48'h1, 48'h0, 48'h0, 48'h1, 48'hFFFFFFFFFFFF, 48'h0};
    repeat (2) @(negedge clk);
    chk("rst_c", c0, 0);
    chk("rst_rden", rden0, 0);
    chk("rst_wren", wren0, 0);
    chk("rst_busy", busy0, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    push0(48'd3);
    push0(48'd5);
    push0(48'd6);
    push0(48'd7);
    rm = '0;
    wm = '0;
    for (int i = 1; i < 14; i++) begin
      @(negedge clk);
      rm[i] = rden0;
      wm[i] = wren0;
    end
    chk("lat_rden", rm, 14'h2412);
    chk("lat_wren", wm, 14'h0180);
    wait_q(0, 4);
    chk("lat_w0", o0[0], 48'h0);
    chk("lat_w1", o0[1], 48'hF);
    chk("lat_w2", o0[2], 48'h0);
    chk("lat_w3", o0[3], 48'h2A);
    repeat (4) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      clear_q();
      push0(tv[i].x);
      push0(tv[i].y);
      wait_q(0, 2);
      wait_q(1, 2);
      wait_q(2, 2);
      chk($sformatf("v%0d_msw0", i), o0[0], tv[i].m0);
      chk($sformatf("v%0d_msw1", i), o0[1], tv[i].m1);
      chk($sformatf("v%0d_lsw0", i), o1[0], tv[i].l0);
      chk($sformatf("v%0d_lsw1", i), o1[1], tv[i].l1);
      chk($sformatf("v%0d_sgn0", i), o2[0], tv[i].s0);
      chk($sformatf("v%0d_sgn1", i), o2[1], tv[i].s1);
    end
    repeat (4) @(negedge clk);
    clear_q();
    push3(48'd2);
    push3(48'd3);
    wait_rden(3, 2);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("gap_rden%0d", i), rden3, 0);
      chk($sformatf("gap_busy%0d", i), busy3, 1);
    end
    push3(48'd4);
    wait_q(3, 3);
    chk("n3_w0", o3[0], 48'h0);
    chk("n3_w1", o3[1], 48'h0);
    chk("n3_w2", o3[2], 48'h18);
    repeat (4) @(negedge clk);
    chk("n3_idle", busy3, 0);
    clear_q();
    push0(48'hFFFFFFFFFFFF);
    push0(48'hFFFFFFFFFFFF);
    for (int i = 0; i < 100 && !wren0; i++) @(negedge clk);
    chk("stall_first", c0, 48'hFFFFFFFFFFFE);
    full = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("stall_wren%0d", i), wren0, 0);
      chk($sformatf("stall_c%0d", i), c0, 48'hFFFFFFFFFFFE);
    end
    full = 1'b0;
    @(negedge clk);
    chk("stall_rel_wren", wren0, 1);
    chk("stall_rel_c", c0, 48'h1);
    repeat (5) @(negedge clk);
    chk("stall_pulses", o0.size(), 2);
    clear_q();
    push0(48'd9);
    push0(48'd11);
    wait_rden(0, 2);
    @(negedge clk);
    chk("wt_busy", busy0, 1);
    rst_n = 1'b0;
    #1;
    chk("ar_c", c0, 0);
    chk("ar_rden", rden0, 0);
    chk("ar_wren", wren0, 0);
    chk("ar_busy", busy0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("ar_no_wren", o0.size(), 0);
    push0(48'd6);
    push0(48'd7);
    wait_q(0, 2);
    chk("ar_w0", o0[0], 48'h0);
    chk("ar_w1", o0[1], 48'h2A);
`ifdef MUL_CHAIN_CNT_EN
    repeat (2) @(negedge clk);
    chk("ar_cnt", cnt0, 16'd1);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule

// File: doc/mul_chain.md
Name: mul_chain

Overview:
- Parametrised successor to the calc_ops two-operand multiplier. Pops NUM_OPS operands from an input FIFO and forms their running product iteratively. Pushes the exact NUM_OPS*RAH_PACKET_WIDTH-bit result to an output FIFO as NUM_OPS packets.
- Adds output back-pressure (full), per-operand empty checking, signed mode, selectable word order and an async active-low reset.
- Sits between RAH RX and TX FIFOs in the calc_ops example.

Parameters:
- RAH_PACKET_WIDTH, 48: operand and output packet width W.
- NUM_OPS, 2: operands per result, range 2..4. Product width P = NUM_OPS*W. Output words per result = NUM_OPS.
- SIGNED, 0: 1 = operands are two's complement and are sign-extended to P bits; 0 = zero-extended.
- MSW_FIRST, 1: 1 = most-significant word pushed first; 0 = least-significant first.

Ports:
- clk  in  1: clock; all state changes on the rising edge.
- rst_n  in  1: reset, asynchronous, active-low.
- a  in  W: input FIFO read data.
- empty  in  1: input FIFO empty.
- full  in  1: output FIFO full.
- rden  out  1: input FIFO read strobe.
- c  out  W: output FIFO write data.
- wren  out  1: output FIFO write strobe.
- busy  out  1: high whenever state is not IDLE or any operand is held.

Behaviour:
- Reset (rst_n low, asynchronous): c=0, rden=0, wren=0, busy=0, state=IDLE, operand index=0, word index=0, accumulator=0. Reset mid-operation discards any partial result; no further wren occurs until new operands arrive.
- Input FIFO contract: non-show-ahead. Data for a read is valid on a during the cycle after the cycle in which rden was high.
- States:
  - IDLE/FETCH: rden=0, wren=0. If empty=0: rden<=1, go to RD. Otherwise hold. The state is re-entered between operands, so empty is checked before every operand. A mid-result empty gap only stalls; it never reads a stale value.
  - RD: rden<=0 (rden is exactly one cycle wide per operand); go to WT.
  - WT: sample a. If index=0: acc<=ext(a). Else: acc<=(acc*ext(a))[P-1:0], which is exact because the product of NUM_OPS W-bit values fits in P bits. If index=NUM_OPS-1: index<=0, word index<=0, go to WRITE. Else: index++, go to FETCH.
  - WRITE: if full=0, c<=selected word and wren<=1 for that cycle, then word index++. If full=1, wren<=0 and c and the word index hold. After the last word is written, go to IDLE and wren returns to 0 on the next edge.
- Word selection: word k of the push sequence is acc[(NUM_OPS-k)*W-1 -: W] when MSW_FIRST=1, and acc[(k+1)*W-1 -: W] otherwise.
- Latency (NUM_OPS=2, operands already present, full=0):
  - rden pulses on cycles 1 and 4.
  - wren is high on cycles 7 and 8.
  - Next rden is on cycle 10 at the earliest.
- Throughput: one result per 3*NUM_OPS+NUM_OPS+1 cycles without stalls.
- full is sampled only in WRITE. Simultaneous empty=0 and full=1 while in WRITE has no effect until the write finishes; the block never reads ahead.
- The multiply is a single-cycle combinational P x P truncated multiply into acc. No pipelining.

Optional Feature:
- Macro: MUL_CHAIN_CNT_EN.
- Defined: adds output result_cnt (16 bits).
  - Reset to 0.
  - Increments by 1 on the edge that writes the last word of each result.
  - Wraps from 0xFFFF to 0x0000.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Test Plan:
- W=48, NUM_OPS=2, unsigned. Push 3, 5 -> words 0x000000000000, 0x00000000000F in that order; rden/wren timing exactly as in the latency rule above.
- Push 0xFFFFFFFFFFFF, 0xFFFFFFFFFFFF -> 0xFFFFFFFFFFFE then 0x000000000001. Repeat with MSW_FIRST=0 -> same two words in reverse order.
- SIGNED=1: push 0xFFFFFFFFFFFE (-2), 3 -> 0xFFFFFFFFFFFF, 0xFFFFFFFFFFFA. Push -1, -1 -> 0, 1.
- NUM_OPS=3: push 2, 3, 4 with empty held high for 5 cycles between operands 2 and 3 -> no extra rden; output 0, 0, 0x18; busy high throughout.
- full high for 4 cycles after the first output word -> wren low and c held during the stall; second word written on the first cycle after full drops; exactly 2 wren pulses total.
- Reset asserted in the WT state of operand 2 -> all outputs 0 immediately. After release, a fresh 6, 7 yields 0, 0x2A. With MUL_CHAIN_CNT_EN defined, result_cnt reads 1.
